cv32e40p_instr_obi_responder: RTL and testbench
===============================================

CV32E40P_INSTR_OBI_RESPONDER -- requirements
Module: cv32e40p_instr_obi_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the maximum number of outstanding granted-but-unanswered transactions (DEPTH >= 2).
REQ-002 The block SHALL have parameter MEM_WORDS, default 1024, giving the number of 32-bit words backed by the memory port.
REQ-003 The block SHALL have the following ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- instr_req_i  input  1  OBI A-channel request from the fetch initiator.
- instr_addr_i  input  32  request address; bits [1:0] ignored (word fetch).
- instr_gnt_o  output  1  OBI grant; a transaction is accepted when instr_req_i and instr_gnt_o are both 1.
- instr_rvalid_o  output  1  OBI R-channel response valid; the initiator is always ready.
- instr_rdata_o  output  32  response data, valid with instr_rvalid_o.
- instr_err_o  output  1  response error, valid with instr_rvalid_o.
- gnt_stall_i  input  1  test and arbitration throttle; 1 forces instr_gnt_o to 0.
- resp_stall_i  input  1  1 holds back instr_rvalid_o for the current cycle.
- mem_req_o  output  1  synchronous memory read strobe.
- mem_addr_o  output  $clog2(MEM_WORDS)  memory word index.
- mem_rdata_i  input  32  read data, valid exactly one cycle after mem_req_o.

Function
REQ-004 Outstanding counter cnt_q, width $clog2(DEPTH)+1:
- +1 on accepted request; -1 when instr_rvalid_o=1.
- Both in the same cycle: unchanged.
REQ-005 instr_gnt_o SHALL be instr_req_i && !gnt_stall_i && !rst && (cnt_q < DEPTH), combinationally. It SHALL NOT depend on instr_rvalid_o or resp_stall_i.
REQ-006 On an accepted request in cycle t, word index w = instr_addr_i[31:2] is decoded.
- If w < MEM_WORDS: mem_req_o=1 and mem_addr_o = w[$clog2(MEM_WORDS)-1:0] in cycle t.
- Otherwise: mem_req_o=0 and the transaction is marked error.
REQ-007 In-flight register: pend_q and err_q SHALL be set at the end of cycle t for each accepted request, and cleared when no request is accepted.
REQ-008 In cycle t+1 with pend_q=1, the response word SHALL be {rdata = err_q ? 32'h0 : mem_rdata_i, err = err_q}.
REQ-009 Response FIFO: DEPTH entries of {rdata, err}, in-order, with read/write pointers and a wrap bit.
REQ-010 Response selection each cycle:
- FIFO non-empty and !resp_stall_i: output the FIFO head and pop it. Any in-flight response is pushed.
- FIFO empty, pend_q=1, !resp_stall_i: the in-flight response bypasses to the outputs in the same cycle (minimum latency 1 cycle after grant). No push.
- resp_stall_i=1: instr_rvalid_o=0, and any in-flight response is pushed.
REQ-011 Responses SHALL be returned in grant order, exactly one response per accepted request, with none dropped or duplicated.
REQ-012 The FIFO SHALL never overflow, because cnt_q bounds (FIFO count + pend_q) <= DEPTH. A push while full is a design error and SHALL be covered by an assertion.
REQ-013 When instr_rvalid_o=0, instr_rdata_o and instr_err_o SHALL be 0.
REQ-014 The error response SHALL not stall the pipeline; it is timed identically to a normal read.
REQ-015 The block SHALL sustain back-to-back grants, one per cycle, while cnt_q < DEPTH and there are no stalls.

Reset
REQ-016 While rst=1, the following SHALL be forced to 0 in the same cycle: instr_gnt_o, instr_rvalid_o, mem_req_o.
REQ-017 At the first clock edge with rst=1:
- cnt_q=0, pend_q=0, err_q=0.
- FIFO pointers = 0.
- Any in-flight or queued responses are discarded.
REQ-018 Reset asserted mid-operation SHALL discard all outstanding transactions. The first cycle after reset deasserts SHALL accept a new request.

Verification
REQ-019 Single fetch: memory word 5 = 32'hDEADBEEF; req with addr 0x14 at t, no stalls -> gnt=1 at t, mem_req=1 with mem_addr=5 at t; rvalid=1 with rdata=32'hDEADBEEF and err=0 at t+1.
REQ-020 Throughput: continuous req at addrs 0x0, 0x4, 0x8, ... with no stalls -> gnt=1 every cycle; rvalid every cycle from t+1; cnt_q stays at 1.
REQ-021 Backpressure: resp_stall_i=1 with DEPTH=4 and continuous req -> exactly 4 grants, then gnt=0. On stall release -> 4 consecutive in-order rvalids; gnt reasserts in the cycle after the first rvalid.
REQ-022 Error: req addr 0x1000 with MEM_WORDS=1024 -> mem_req=0; at t+1 rvalid=1, err=1, rdata=0. A following valid request is unaffected.
REQ-023 Mixed stall: alternate resp_stall_i every cycle during 8 back-to-back fetches -> all 8 responses in order; the FIFO-empty bypass is exercised; no overflow assertion fires.
REQ-024 Reset mid-flight: 3 transactions outstanding with resp_stall_i=1, assert rst for 1 cycle -> no rvalid during or after reset for those transactions; cnt_q=0; a new request is granted in the first cycle after reset.

Source files
------------

// File: rtl/cv32e40p_instr_obi_responder.sv
// -----------------------------------------------------------------------------
// cv32e40p_instr_obi_responder
//
// OBI instruction-side responder backed by a synchronous single-port memory.
// Accepts word fetches from the core, reads the backing memory (one-cycle read
// latency), and returns responses strictly in grant order. Out-of-range word
// addresses produce an error response with zero data, timed like a normal read.
// A DEPTH-entry response FIFO absorbs responses while the initiator-side
// response is throttled by resp_stall_i. When the FIFO is empty, a fresh read
// bypasses straight to the outputs one cycle after its grant.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   instr_req_i      : OBI A-channel request
//   instr_addr_i     : request byte address, bits [1:0] ignored
//   instr_gnt_o      : OBI grant (combinational)
//   instr_rvalid_o   : OBI R-channel valid (initiator always ready)
//   instr_rdata_o    : response data, zero when rvalid is low
//   instr_err_o      : response error, zero when rvalid is low
//   gnt_stall_i      : forces grant low
//   resp_stall_i     : holds back rvalid for the current cycle
//   mem_req_o        : memory read strobe
//   mem_addr_o       : memory word index
//   mem_rdata_i      : memory read data, valid one cycle after mem_req_o
// -----------------------------------------------------------------------------
module cv32e40p_instr_obi_responder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instr_req_i,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic                         instr_err_o,
  input  logic                         gnt_stall_i,
  input  logic                         resp_stall_i,
  output logic                         mem_req_o,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
  input  logic [31:0]                  mem_rdata_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned AW = $clog2(MEM_WORDS);

  // Outstanding-transaction counter
  logic [CW-1:0] cnt_q, cnt_d;

  // In-flight stage: a read issued last cycle whose data is on mem_rdata_i now
  logic          pend_q, pend_d;
  logic          err_q, err_d;

  // FIFO pointers stored as {wrap, index}
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic [32:0]   fifo_q [DEPTH];

  logic          accept_s;
  logic          in_range_s;
  logic [29:0]   word_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          push_s;
  logic          pop_s;
  logic [32:0]   resp_word_s;
  logic          unused_addr_s;

  // Advance a {wrap, index} pointer; handles DEPTH that is not a power of two.
  function automatic logic [PW:0] ptr_inc(input logic [PW:0] p);
    logic [PW:0] r;
    if (p[PW-1:0] == PW'(DEPTH - 1)) begin
      r = {~p[PW], {PW{1'b0}}};
    end else begin
      r = {p[PW], p[PW-1:0] + PW'(1)};
    end
    return r;
  endfunction

  assign unused_addr_s = ^instr_addr_i[1:0];
  assign word_s        = instr_addr_i[31:2];

  // Request side: grant, address decode and memory strobe.
  always_comb begin
    instr_gnt_o = instr_req_i && !gnt_stall_i && !rst && (cnt_q < CW'(DEPTH));
    accept_s    = instr_gnt_o;
    in_range_s  = ({2'b00, word_s} < 32'(MEM_WORDS));
    mem_req_o   = accept_s && in_range_s;
    mem_addr_o  = word_s[AW-1:0];
  end

  // FIFO occupancy flags.
  always_comb begin
    fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    fifo_full_s  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
  end

  // Error responses carry zero data regardless of what the memory bus holds.
  always_comb begin
    resp_word_s = {err_q, (err_q ? 32'h0000_0000 : mem_rdata_i)};
  end

  // Response selection: FIFO head first, else in-flight bypass, else park it.
  always_comb begin
    push_s         = 1'b0;
    pop_s          = 1'b0;
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = 32'h0000_0000;
    instr_err_o    = 1'b0;
    if (rst) begin
      push_s = 1'b0;
    end else if (!resp_stall_i) begin
      if (!fifo_empty_s) begin
        instr_rvalid_o = 1'b1;
        instr_err_o    = fifo_q[rd_ptr_q[PW-1:0]][32];
        instr_rdata_o  = fifo_q[rd_ptr_q[PW-1:0]][31:0];
        pop_s          = 1'b1;
        push_s         = pend_q;
      end else if (pend_q) begin
        instr_rvalid_o = 1'b1;
        instr_err_o    = resp_word_s[32];
        instr_rdata_o  = resp_word_s[31:0];
      end else begin
        instr_rvalid_o = 1'b0;
      end
    end else begin
      push_s = pend_q;
    end
  end

  // Next-state for counter, in-flight stage and pointers.
  always_comb begin
    case ({accept_s, instr_rvalid_o})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    pend_d   = accept_s;
    err_d    = accept_s && !in_range_s;
    wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  // Control state registers; reset discards everything in flight or queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q[PW-1:0]] <= resp_word_s;
    end
  end

  cv32e40p_instr_obi_responder_chk #(
    .CW (CW)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .full_i  (fifo_full_s),
    .cnt_i   (cnt_q),
    .depth_i (CW'(DEPTH))
  );

endmodule

// -----------------------------------------------------------------------------
// cv32e40p_instr_obi_responder_chk
//
// Invariant checks for the responder: the FIFO is never written while full and
// the outstanding count never exceeds DEPTH.
//
// Ports
//   clk, rst : clock, synchronous active-high reset
//   push_i   : FIFO write strobe
//   full_i   : FIFO full flag
//   cnt_i    : outstanding-transaction count
//   depth_i  : configured DEPTH
// -----------------------------------------------------------------------------
module cv32e40p_instr_obi_responder_chk #(
  parameter int unsigned CW = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          push_i,
  input logic          full_i,
  input logic [CW-1:0] cnt_i,
  input logic [CW-1:0] depth_i
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_i));

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_i <= depth_i);

endmodule

// File: tb/tb_cv32e40p_instr_obi_responder.sv
module tb_cv32e40p_instr_obi_responder;

  localparam int DEPTH     = 4;
  localparam int MEM_WORDS = 1024;

  logic        clk;
  logic        rst;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        gnt_stall_i;
  logic        resp_stall_i;
  logic        mem_req_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] mem [MEM_WORDS];
  logic [32:0] exp_q [$];

  int checks;
  int failures;

  cv32e40p_instr_obi_responder #(
    .DEPTH     (DEPTH),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .gnt_stall_i    (gnt_stall_i),
    .resp_stall_i   (resp_stall_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_req_o) mem_rdata_i <= mem[mem_addr_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] expected_resp(input logic [31:0] addr);
    logic [29:0] w;
    w = addr[31:2];
    if (w < 30'(MEM_WORDS)) return {1'b0, mem[w[9:0]]};
    else return {1'b1, 32'h0000_0000};
  endfunction

  // Scoreboard monitor: pops on every rvalid, pushes on every accepted request.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      exp_q.delete();
      chk("rst_gnt", {31'd0, instr_gnt_o}, 32'd0);
      chk("rst_rvalid", {31'd0, instr_rvalid_o}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    end else begin
      if (instr_rvalid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_rdata", instr_rdata_o, e[31:0]);
          chk("sb_err", {31'd0, instr_err_o}, {31'd0, e[32]});
        end
      end else begin
        chk("idle_rdata_zero", instr_rdata_o, 32'd0);
        chk("idle_err_zero", {31'd0, instr_err_o}, 32'd0);
      end
      if (instr_req_i && instr_gnt_o) begin
        e = expected_resp(instr_addr_i);
        exp_q.push_back(e);
        chk("mem_req", {31'd0, mem_req_o}, {31'd0, ~e[32]});
        if (!e[32]) chk("mem_addr", {22'd0, mem_addr_o}, {22'd0, instr_addr_i[11:2]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0001;
    mem[5]       = 32'hDEAD_BEEF;
    mem_rdata_i  = 32'h0;
    rst          = 1'b1;
    instr_req_i  = 1'b0;
    instr_addr_i = 32'h0;
    gnt_stall_i  = 1'b0;
    resp_stall_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("reset_cnt", 32'(dut.cnt_q), 32'd0);
    chk("reset_rvalid", {31'd0, instr_rvalid_o}, 32'd0);
    tick();

    // Single fetch of word 5.
    instr_req_i = 1'b1; instr_addr_i = 32'h14;
    settle();
    chk("single_gnt", {31'd0, instr_gnt_o}, 32'd1);
    chk("single_mem_req", {31'd0, mem_req_o}, 32'd1);
    chk("single_mem_addr", {22'd0, mem_addr_o}, 32'd5);
    tick();
    instr_req_i = 1'b0;
    settle();
    chk("single_rvalid", {31'd0, instr_rvalid_o}, 32'd1);
    chk("single_rdata", instr_rdata_o, 32'hDEAD_BEEF);
    chk("single_err", {31'd0, instr_err_o}, 32'd0);
    tick();

    // Back-to-back throughput.
    for (int i = 0; i < 8; i++) begin
      instr_req_i = 1'b1; instr_addr_i = 32'(i * 4);
      settle();
      chk("tput_gnt", {31'd0, instr_gnt_o}, 32'd1);
      if (i > 0) begin
        chk("tput_rvalid", {31'd0, instr_rvalid_o}, 32'd1);
        chk("tput_cnt", 32'(dut.cnt_q), 32'd1);
      end
      tick();
    end
    instr_req_i = 1'b0;
    tick(); tick();

    // Backpressure: four grants, then stall release.
    resp_stall_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      instr_req_i = 1'b1; instr_addr_i = 32'h100 + 32'(i * 4);
      settle();
      chk("bp_gnt", {31'd0, instr_gnt_o}, (i < 4) ? 32'd1 : 32'd0);
      chk("bp_rvalid", {31'd0, instr_rvalid_o}, 32'd0);
      tick();
    end
    resp_stall_i = 1'b0;
    instr_addr_i = 32'h180;
    settle();
    chk("bp_rel_rvalid0", {31'd0, instr_rvalid_o}, 32'd1);
    chk("bp_rel_gnt0", {31'd0, instr_gnt_o}, 32'd0);
    tick();
    settle();
    chk("bp_rel_rvalid1", {31'd0, instr_rvalid_o}, 32'd1);
    chk("bp_rel_gnt1", {31'd0, instr_gnt_o}, 32'd1);
    tick();
    instr_req_i = 1'b0;
    settle();
    chk("bp_rel_rvalid2", {31'd0, instr_rvalid_o}, 32'd1);
    tick();
    settle();
    chk("bp_rel_rvalid3", {31'd0, instr_rvalid_o}, 32'd1);
    tick(); tick(); tick();

    // Error response followed by a valid fetch.
    instr_req_i = 1'b1; instr_addr_i = 32'h1000;
    settle();
    chk("err_gnt", {31'd0, instr_gnt_o}, 32'd1);
    chk("err_mem_req", {31'd0, mem_req_o}, 32'd0);
    tick();
    instr_addr_i = 32'h20;
    settle();
    chk("err_rvalid", {31'd0, instr_rvalid_o}, 32'd1);
    chk("err_flag", {31'd0, instr_err_o}, 32'd1);
    chk("err_rdata", instr_rdata_o, 32'd0);
    chk("err_next_mem_req", {31'd0, mem_req_o}, 32'd1);
    tick();
    instr_req_i = 1'b0;
    settle();
    chk("err_next_err", {31'd0, instr_err_o}, 32'd0);
    chk("err_next_rdata", instr_rdata_o, 32'h1000_0000 + 32'd8 * 32'h0001_0001);
    tick(); tick();

    // Alternating response stall over 8 fetches.
    k = 0; n = 0;
    while ((k < 8 || exp_q.size() != 0) && n < 60) begin
      resp_stall_i = (n % 2 == 0);
      instr_req_i  = (k < 8);
      instr_addr_i = 32'h200 + 32'(k * 4);
      settle();
      if (instr_req_i && instr_gnt_o) k++;
      tick();
      n++;
    end
    instr_req_i = 1'b0; resp_stall_i = 1'b0;
    chk("mix_grants", 32'(k), 32'd8);
    chk("mix_drained", 32'(exp_q.size()), 32'd0);
    tick();

    // Reset while three transactions are outstanding.
    resp_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_req_i = 1'b1; instr_addr_i = 32'h300 + 32'(i * 4);
      tick();
    end
    instr_req_i = 1'b0;
    tick();
    rst = 1'b1; instr_req_i = 1'b1; instr_addr_i = 32'h40;
    settle();
    chk("mid_rst_gnt", {31'd0, instr_gnt_o}, 32'd0);
    tick();
    rst = 1'b0; resp_stall_i = 1'b0; instr_addr_i = 32'h44;
    settle();
    chk("post_rst_cnt", 32'(dut.cnt_q), 32'd0);
    chk("post_rst_rvalid", {31'd0, instr_rvalid_o}, 32'd0);
    chk("post_rst_gnt", {31'd0, instr_gnt_o}, 32'd1);
    tick();
    instr_req_i = 1'b0;
    settle();
    chk("post_rst_rdata", instr_rdata_o, 32'h1000_0000 + 32'd17 * 32'h0001_0001);
    tick();

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
